// File: rtl/srrc_sym_fir_pipe.sv
// Pipelined odd-length symmetric FIR (pre-add folded) with double-buffered runtime coefficients.
// Four register stages follow the delay line: pre-add, multiply, adder tree, then round and saturate.
module srrc_sym_fir_pipe #(
    parameter int DW        = 18,
    parameter int CW        = 18,
    parameter int NTAPS     = 17,
    parameter int OUT_SHIFT = 16,
    parameter int AW        = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in,
    input  logic          in_valid,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    input  logic          coef_swap,
    output logic [DW-1:0] out,
    output logic          out_valid,
    output logic          sat
);
    localparam int NCOEF = (NTAPS + 1) / 2;
    localparam int LOGN  = (NCOEF > 1) ? $clog2(NCOEF) : 1;
    localparam int PW    = DW + 1;
    localparam int MW    = PW + CW;
    localparam int ACW   = MW + LOGN;
    localparam int RW    = ACW + 1;

    localparam logic signed [RW-1:0] HALF = RW'(1) <<< (OUT_SHIFT - 1);
    localparam logic signed [RW-1:0] MAXV = (RW'(1) <<< (DW - 1)) - RW'(1);
    localparam logic signed [RW-1:0] MINV = -(RW'(1) <<< (DW - 1));
    localparam logic [DW-1:0] OMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] OMIN = {1'b1, {(DW-1){1'b0}}};

    logic signed [DW-1:0]  x_reg      [NTAPS];
    logic signed [CW-1:0]  shadow_reg [NCOEF];
    logic signed [CW-1:0]  active_reg [NCOEF];
    logic signed [PW-1:0]  p_reg      [NCOEF];
    logic signed [MW-1:0]  m_reg      [NCOEF];
    logic signed [ACW-1:0] acc_reg;
    logic signed [ACW-1:0] acc_next;
    logic signed [RW-1:0]  rnd_next;
    logic signed [RW-1:0]  r_next;
    logic [3:0]            v_reg;
    logic [DW-1:0]         out_reg;
    logic                  out_valid_reg;
    logic                  sat_reg;

    // Delay line: advances only on accepted samples
    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_tap
            always_ff @(posedge clk) begin
                if (reset) begin
                    x_reg[gi] <= '0;
                end else if (in_valid) begin
                    if (gi == 0) begin
                        x_reg[gi] <= in;
                    end else begin
                        x_reg[gi] <= x_reg[(gi > 0) ? gi - 1 : 0];
                    end
                end
            end
        end
    endgenerate

    // Coefficient banks; the swap reads shadow before any same-edge write lands
    generate
        for (gi = 0; gi < NCOEF; gi++) begin : g_coef
            localparam logic [AW-1:0] IDX = AW'(gi);
            localparam logic signed [CW-1:0] RST_ACTIVE =
                (gi == NCOEF - 1) ? (CW'(1) <<< OUT_SHIFT) : '0;

            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_reg[gi] <= '0;
                end else if (coef_we && (coef_addr == IDX)) begin
                    shadow_reg[gi] <= coef_data;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    active_reg[gi] <= RST_ACTIVE;
                end else if (coef_swap) begin
                    active_reg[gi] <= shadow_reg[gi];
                end
            end
        end
    endgenerate

    // S1 pre-add and S2 multiply
    generate
        for (gi = 0; gi < NCOEF; gi++) begin : g_mac
            if (gi < NCOEF - 1) begin : g_pair
                always_ff @(posedge clk) begin
                    if (reset) begin
                        p_reg[gi] <= '0;
                    end else begin
                        p_reg[gi] <= {x_reg[gi][DW-1], x_reg[gi]}
                                   + {x_reg[NTAPS-1-gi][DW-1], x_reg[NTAPS-1-gi]};
                    end
                end
            end else begin : g_centre
                always_ff @(posedge clk) begin
                    if (reset) begin
                        p_reg[gi] <= '0;
                    end else begin
                        p_reg[gi] <= {x_reg[gi][DW-1], x_reg[gi]};
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    m_reg[gi] <= '0;
                end else begin
                    m_reg[gi] <= MW'(p_reg[gi]) * MW'(active_reg[gi]);
                end
            end
        end
    endgenerate

    // S3 full-precision adder tree
    always_comb begin
        acc_next = '0;
        for (int k = 0; k < NCOEF; k++) begin
            acc_next = acc_next + ACW'(m_reg[k]);
        end
    end

    // S4 round half up, arithmetic shift, then clip to DW
    always_comb begin
        rnd_next = RW'(acc_reg) + HALF;
        r_next   = rnd_next >>> OUT_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_reg         <= '0;
            acc_reg       <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            sat_reg       <= 1'b0;
        end else begin
            v_reg         <= {v_reg[2:0], in_valid};
            acc_reg       <= acc_next;
            out_valid_reg <= v_reg[3];
            if (v_reg[3]) begin
                if (r_next > MAXV) begin
                    out_reg <= OMAX;
                    sat_reg <= 1'b1;
                end else if (r_next < MINV) begin
                    out_reg <= OMIN;
                    sat_reg <= 1'b1;
                end else begin
                    out_reg <= r_next[DW-1:0];
                    sat_reg <= 1'b0;
                end
            end
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign sat       = sat_reg;

endmodule

// File: tb/tb_srrc_sym_fir_pipe.sv
// Directed bench for srrc_sym_fir_pipe: identity, loaded taps, rounding/saturation, strobe gaps,
// coefficient corner cases and mid-stream reset, checked with immediate assertions.
module tb_srrc_sym_fir_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] in_s;
    logic        in_valid;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [17:0] coef_data;
    logic        coef_swap;
    logic [17:0] out_s;
    logic        out_valid;
    logic        sat;

    int n_cmp = 0;
    int n_bad = 0;
    int vq[$];
    int sq[$];
    int ovq[$];
    int c[9] = '{314, -2115, -5743, -6936, -719, 15367, 37897, 57966, 66023};
    int exp_ov[9] = '{0, 0, 0, 0, 1, 0, 1, 1, 0};

    always #5 clk = ~clk;

    srrc_sym_fir_pipe #(.DW(18), .CW(18), .NTAPS(17), .OUT_SHIFT(16), .AW(4)) dut (
        .clk(clk), .reset(reset), .in(in_s), .in_valid(in_valid),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_swap(coef_swap), .out(out_s), .out_valid(out_valid), .sat(sat)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic v, input int d);
        in_valid = v;
        in_s = 18'(d);
        @(posedge clk);
        #1;
        ovq.push_back(int'(out_valid));
        if (out_valid === 1'b1) begin
            vq.push_back(int'($signed(out_s)));
            sq.push_back(int'(sat));
        end
    endtask

    task automatic clearq();
        vq.delete();
        sq.delete();
        ovq.delete();
    endtask

    task automatic wc(input int a, input int d);
        coef_we = 1'b1;
        coef_addr = 4'(a);
        coef_data = 18'(d);
        tick(1'b0, 0);
        coef_we = 1'b0;
    endtask

    task automatic swap();
        coef_swap = 1'b1;
        tick(1'b0, 0);
        coef_swap = 1'b0;
    endtask

    task automatic flush();
        repeat (17) tick(1'b1, 0);
        repeat (5) tick(1'b0, 0);
        clearq();
    endtask

    task automatic run_imp(input int amp, input int n);
        clearq();
        tick(1'b1, amp);
        repeat (n - 1) tick(1'b1, 0);
        repeat (5) tick(1'b0, 0);
    endtask

    function automatic int gv(input int j);
        return (j < vq.size()) ? vq[j] : -999999;
    endfunction

    function automatic int gs(input int j);
        return (j < sq.size()) ? sq[j] : -1;
    endfunction

    initial begin
        int acc;
        reset = 1'b1; in_s = '0; in_valid = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_swap = 1'b0;
        tick(1'b0, 0);
        tick(1'b0, 0);
        chk("reset_out", 64'($signed(out_s)), 0);
        chk("reset_out_valid", 64'(out_valid), 0);
        chk("reset_sat", 64'(sat), 0);
        reset = 1'b0;

        // Identity after reset: pure delay of 8 samples, 4-cycle latency
        clearq();
        tick(1'b1, 1000);
        repeat (23) tick(1'b1, 0);
        repeat (4) tick(1'b0, 0);
        for (int j = 0; j < 8; j++) chk($sformatf("ident_ov[%0d]", j), ovq[j], (j >= 4) ? 1 : 0);
        chk("ident_count", vq.size(), 24);
        acc = 0;
        for (int j = 0; j < 24; j++) begin
            chk($sformatf("ident_out[%0d]", j), gv(j), (j == 8) ? 1000 : 0);
            acc += gs(j);
        end
        chk("ident_sat", acc, 0);

        // Loaded SRRC taps, impulse of 65536 returns the taps themselves
        for (int k = 0; k < 9; k++) wc(k, c[k]);
        swap();
        run_imp(65536, 24);
        chk("taps_count", vq.size(), 24);
        for (int j = 0; j < 24; j++)
            chk($sformatf("taps_out[%0d]", j), gv(j), (j <= 16) ? c[(j <= 8) ? j : 16 - j] : 0);

        // Rounding with centre 32768
        for (int k = 0; k < 8; k++) wc(k, 0);
        wc(8, 32768);
        swap();
        flush();
        repeat (12) tick(1'b1, 1);
        repeat (5) tick(1'b0, 0);
        chk("round_pos_pre", gv(7), 0);
        chk("round_pos", gv(11), 1);
        chk("round_pos_sat", gs(11), 0);
        clearq();
        repeat (12) tick(1'b1, -1);
        repeat (5) tick(1'b0, 0);
        chk("round_neg", gv(11), 0);

        // Saturation with centre 131071
        wc(8, 131071);
        swap();
        clearq();
        repeat (12) tick(1'b1, 131071);
        repeat (5) tick(1'b0, 0);
        chk("sat_hi_out", gv(11), 131071);
        chk("sat_hi_flag", gs(11), 1);
        clearq();
        repeat (12) tick(1'b1, -131072);
        repeat (5) tick(1'b0, 0);
        chk("sat_lo_out", gv(11), -131072);
        chk("sat_lo_flag", gs(11), 1);

        // Strobe gaps with identity taps
        wc(8, 65536);
        swap();
        flush();
        tick(1'b1, 100);
        tick(1'b0, 999);
        tick(1'b1, 200);
        tick(1'b1, 300);
        tick(1'b0, 999);
        repeat (6) tick(1'b1, 0);
        repeat (5) tick(1'b0, 0);
        for (int j = 0; j < 9; j++) chk($sformatf("gap_ov[%0d]", j), ovq[j], exp_ov[j]);
        chk("gap_count", vq.size(), 9);
        chk("gap_out7", gv(7), 0);
        chk("gap_out8", gv(8), 100);

        // Out-of-range write is ignored
        wc(12, 5000);
        swap();
        run_imp(1000, 17);
        chk("oor_out4", gv(4), 0);
        chk("oor_out8", gv(8), 1000);
        chk("oor_out12", gv(12), 0);

        // Same-edge write and swap: active keeps the pre-write shadow value
        coef_we = 1'b1; coef_addr = 4'd8; coef_data = '0; coef_swap = 1'b1;
        tick(1'b0, 0);
        coef_we = 1'b0; coef_swap = 1'b0;
        run_imp(1000, 17);
        chk("same_edge_out8", gv(8), 1000);
        swap();
        run_imp(1000, 17);
        chk("second_swap_out8", gv(8), 0);

        // Mid-stream reset discards in-flight samples and restores identity
        clearq();
        tick(1'b1, 1000);
        reset = 1'b1;
        tick(1'b0, 0);
        reset = 1'b0;
        chk("mid_reset_ov", 64'(out_valid), 0);
        chk("mid_reset_out", 64'($signed(out_s)), 0);
        clearq();
        repeat (6) tick(1'b0, 0);
        acc = 0;
        foreach (ovq[j]) acc += ovq[j];
        chk("mid_reset_no_valid", acc, 0);
        clearq();
        repeat (12) tick(1'b1, 0);
        repeat (5) tick(1'b0, 0);
        acc = 0;
        foreach (vq[j]) acc += (vq[j] < 0) ? -vq[j] : vq[j];
        chk("mid_reset_no_impulse", acc, 0);
        run_imp(1000, 17);
        chk("mid_reset_identity", gv(8), 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
